// File: rtl/taxi_axis_frame_xbar.sv
// AXI4-Stream frame crossbar: CNT inputs, CNT outputs, one clock domain.
// Each input latches its destination/drop setting at the first beat of a frame,
// then either forwards the whole frame to one output or discards it.
// Each output runs a round-robin frame-level arbiter feeding one output register.
//
// Ports (flattened per-port buses, port n occupies slice n):
//   clk, rst            clock, asynchronous active-high reset
//   s_axis_*            input streams (tdata, tkeep, tvalid, tready, tlast, tid, tuser)
//   m_axis_*            output streams, same fields
//   cfg_dest            destination output index per input ($clog2(CNT) bits each)
//   cfg_drop            1 = discard frames arriving on that input
//   stat_clr            synchronous clear of all counters
//   stat_tx_frames      saturating frames-completed count per output
//   stat_drop_frames    saturating frames-discarded count per input
module taxi_axis_frame_xbar #(
    parameter int CNT    = 2,
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1,
    parameter int STAT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT*DATA_W-1:0]      s_axis_tdata,
    input  logic [CNT*KEEP_W-1:0]      s_axis_tkeep,
    input  logic [CNT-1:0]             s_axis_tvalid,
    output logic [CNT-1:0]             s_axis_tready,
    input  logic [CNT-1:0]             s_axis_tlast,
    input  logic [CNT*ID_W-1:0]        s_axis_tid,
    input  logic [CNT*USER_W-1:0]      s_axis_tuser,
    output logic [CNT*DATA_W-1:0]      m_axis_tdata,
    output logic [CNT*KEEP_W-1:0]      m_axis_tkeep,
    output logic [CNT-1:0]             m_axis_tvalid,
    input  logic [CNT-1:0]             m_axis_tready,
    output logic [CNT-1:0]             m_axis_tlast,
    output logic [CNT*ID_W-1:0]        m_axis_tid,
    output logic [CNT*USER_W-1:0]      m_axis_tuser,
    input  logic [CNT*$clog2(CNT)-1:0] cfg_dest,
    input  logic [CNT-1:0]             cfg_drop,
    input  logic                       stat_clr,
    output logic [CNT*STAT_W-1:0]      stat_tx_frames,
    output logic [CNT*STAT_W-1:0]      stat_drop_frames
);
    localparam int SEL_W = $clog2(CNT);

    typedef logic [SEL_W-1:0] sel_t;
    typedef enum logic [1:0] {InIdle, InFwd, InDrop} in_state_e;
    typedef enum logic {ArbIdle, ArbActive} arb_state_e;

    // Input side
    in_state_e      in_state_q [CNT];
    in_state_e      in_state_d [CNT];
    sel_t           dest_q [CNT];
    sel_t           dest_d [CNT];
    logic [CNT-1:0] pend_q, pend_d;   // waiting on a busy output with dest_q latched
    sel_t           req_dest [CNT];
    logic [CNT-1:0] req_vld, start_drop, granted, drop_evt;

    // Output side
    arb_state_e     arb_state_q [CNT];
    arb_state_e     arb_state_d [CNT];
    sel_t           grant_q [CNT];
    sel_t           grant_d [CNT];
    sel_t           last_q [CNT];
    sel_t           last_d [CNT];
    sel_t           pick [CNT];
    logic [CNT-1:0] pick_vld, out_ready, beat, frame_end;

    logic [DATA_W-1:0] m_data_q [CNT];
    logic [KEEP_W-1:0] m_keep_q [CNT];
    logic [ID_W-1:0]   m_id_q [CNT];
    logic [USER_W-1:0] m_user_q [CNT];
    logic [CNT-1:0]    m_valid_q, m_last_q;

    logic [STAT_W-1:0] tx_cnt_q [CNT];
    logic [STAT_W-1:0] drop_cnt_q [CNT];

    function automatic logic [STAT_W-1:0] cnt_next(input logic [STAT_W-1:0] cur,
                                                   input logic evt, input logic clr);
        if (clr) return evt ? STAT_W'(1) : '0;
        if (evt && cur != '1) return cur + 1'b1;
        return cur;
    endfunction

    // Request decode: a fresh frame uses live config, a waiting one its latched dest.
    always_comb begin
        req_vld    = '0;
        start_drop = '0;
        for (int n = 0; n < CNT; n++) begin
            req_dest[n] = dest_q[n];
            if (in_state_q[n] == InIdle && s_axis_tvalid[n]) begin
                if (pend_q[n]) begin
                    req_vld[n] = 1'b1;
                end else begin
                    req_dest[n] = cfg_dest[n*SEL_W +: SEL_W];
                    if (cfg_drop[n] || int'(req_dest[n]) >= CNT) begin
                        start_drop[n] = 1'b1;
                    end else begin
                        req_vld[n] = 1'b1;
                    end
                end
            end
        end
    end

    // Round-robin scan starting after the last granted input.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = '0;
        for (int o = 0; o < CNT; o++) begin
            pick[o] = last_q[o];
            if (arb_state_q[o] == ArbIdle) begin
                for (int i = 1; i <= CNT; i++) begin
                    idx = (int'(last_q[o]) + i) % CNT;
                    if (!pick_vld[o] && req_vld[idx] && int'(req_dest[idx]) == o) begin
                        pick_vld[o] = 1'b1;
                        pick[o]     = sel_t'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        granted = '0;
        for (int n = 0; n < CNT; n++) begin
            if (req_vld[n] && pick_vld[req_dest[n]] && pick[req_dest[n]] == sel_t'(n)) begin
                granted[n] = 1'b1;
            end
        end
    end

    // Datapath handshakes; the output register drains and refills in the same cycle.
    always_comb begin
        out_ready     = '0;
        beat          = '0;
        frame_end     = '0;
        s_axis_tready = '0;
        for (int o = 0; o < CNT; o++) begin
            out_ready[o] = !m_valid_q[o] || m_axis_tready[o];
            beat[o]      = arb_state_q[o] == ArbActive && s_axis_tvalid[grant_q[o]] &&
                           out_ready[o];
            frame_end[o] = beat[o] && s_axis_tlast[grant_q[o]];
        end
        for (int n = 0; n < CNT; n++) begin
            if (in_state_q[n] == InFwd) begin
                s_axis_tready[n] = out_ready[dest_q[n]];
            end else if (in_state_q[n] == InDrop) begin
                s_axis_tready[n] = 1'b1;
            end
        end
    end

    // Input FSM next state
    always_comb begin
        drop_evt = '0;
        pend_d   = pend_q;
        for (int n = 0; n < CNT; n++) begin
            in_state_d[n] = in_state_q[n];
            dest_d[n]     = dest_q[n];
            unique case (in_state_q[n])
                InIdle: begin
                    if (start_drop[n]) begin
                        in_state_d[n] = InDrop;
                        dest_d[n]     = req_dest[n];
                    end else if (req_vld[n]) begin
                        dest_d[n] = req_dest[n];
                        pend_d[n] = !granted[n];
                        if (granted[n]) in_state_d[n] = InFwd;
                    end
                end
                InFwd: begin
                    if (s_axis_tvalid[n] && s_axis_tready[n] && s_axis_tlast[n]) begin
                        in_state_d[n] = InIdle;
                    end
                end
                InDrop: begin
                    if (s_axis_tvalid[n] && s_axis_tlast[n]) begin
                        in_state_d[n] = InIdle;
                        drop_evt[n]   = 1'b1;
                    end
                end
                default: in_state_d[n] = InIdle;
            endcase
        end
    end

    // Arbiter FSM next state
    always_comb begin
        for (int o = 0; o < CNT; o++) begin
            arb_state_d[o] = arb_state_q[o];
            grant_d[o]     = grant_q[o];
            last_d[o]      = last_q[o];
            if (arb_state_q[o] == ArbIdle) begin
                if (pick_vld[o]) begin
                    arb_state_d[o] = ArbActive;
                    grant_d[o]     = pick[o];
                    last_d[o]      = pick[o];
                end
            end else if (frame_end[o]) begin
                arb_state_d[o] = ArbIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= '0;
            m_valid_q <= '0;
            m_last_q  <= '0;
            for (int i = 0; i < CNT; i++) begin
                in_state_q[i]  <= InIdle;
                dest_q[i]      <= '0;
                arb_state_q[i] <= ArbIdle;
                grant_q[i]     <= '0;
                last_q[i]      <= sel_t'(CNT - 1);
                m_data_q[i]    <= '0;
                m_keep_q[i]    <= '0;
                m_id_q[i]      <= '0;
                m_user_q[i]    <= '0;
                tx_cnt_q[i]    <= '0;
                drop_cnt_q[i]  <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < CNT; i++) begin
                in_state_q[i]  <= in_state_d[i];
                dest_q[i]      <= dest_d[i];
                arb_state_q[i] <= arb_state_d[i];
                grant_q[i]     <= grant_d[i];
                last_q[i]      <= last_d[i];
                tx_cnt_q[i]    <= cnt_next(tx_cnt_q[i], frame_end[i], stat_clr);
                drop_cnt_q[i]  <= cnt_next(drop_cnt_q[i], drop_evt[i], stat_clr);
                if (beat[i]) begin
                    m_valid_q[i] <= 1'b1;
                    m_data_q[i]  <= s_axis_tdata[grant_q[i]*DATA_W +: DATA_W];
                    m_keep_q[i]  <= s_axis_tkeep[grant_q[i]*KEEP_W +: KEEP_W];
                    m_last_q[i]  <= s_axis_tlast[grant_q[i]];
                    m_id_q[i]    <= s_axis_tid[grant_q[i]*ID_W +: ID_W];
                    m_user_q[i]  <= s_axis_tuser[grant_q[i]*USER_W +: USER_W];
                end else if (m_axis_tready[i]) begin
                    m_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        m_axis_tdata     = '0;
        m_axis_tkeep     = '0;
        m_axis_tid       = '0;
        m_axis_tuser     = '0;
        stat_tx_frames   = '0;
        stat_drop_frames = '0;
        m_axis_tvalid    = m_valid_q;
        m_axis_tlast     = m_last_q;
        for (int i = 0; i < CNT; i++) begin
            m_axis_tdata[i*DATA_W +: DATA_W]     = m_data_q[i];
            m_axis_tkeep[i*KEEP_W +: KEEP_W]     = m_keep_q[i];
            m_axis_tid[i*ID_W +: ID_W]           = m_id_q[i];
            m_axis_tuser[i*USER_W +: USER_W]     = m_user_q[i];
            stat_tx_frames[i*STAT_W +: STAT_W]   = tx_cnt_q[i];
            stat_drop_frames[i*STAT_W +: STAT_W] = drop_cnt_q[i];
        end
    end

endmodule

// File: tb/tb_taxi_axis_frame_xbar.sv
module tb_taxi_axis_frame_xbar;
    localparam int CNT = 4;
    localparam int DW  = 16;
    localparam int KW  = 2;
    localparam int IW  = 8;
    localparam int UW  = 1;
    localparam int SW  = 4;
    localparam int SLW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CNT*DW-1:0]  s_axis_tdata, m_axis_tdata;
    logic [CNT*KW-1:0]  s_axis_tkeep, m_axis_tkeep;
    logic [CNT-1:0]     s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [CNT-1:0]     m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [CNT*IW-1:0]  s_axis_tid, m_axis_tid;
    logic [CNT*UW-1:0]  s_axis_tuser, m_axis_tuser;
    logic [CNT*SLW-1:0] cfg_dest;
    logic [CNT-1:0]     cfg_drop;
    logic               stat_clr;
    logic [CNT*SW-1:0]  stat_tx_frames, stat_drop_frames;

    logic [DW-1:0]  s_data [CNT];
    logic [KW-1:0]  s_keep [CNT];
    logic           s_valid [CNT];
    logic           s_last [CNT];
    logic [IW-1:0]  s_id [CNT];
    logic [UW-1:0]  s_user [CNT];
    logic           s_ready [CNT];
    logic           m_ready [CNT];
    logic           m_valid [CNT];
    logic           m_last [CNT];
    logic [SLW-1:0] dest [CNT];

    for (genvar i = 0; i < CNT; i++) begin : g_map
        assign s_axis_tdata[i*DW +: DW]   = s_data[i];
        assign s_axis_tkeep[i*KW +: KW]   = s_keep[i];
        assign s_axis_tvalid[i]           = s_valid[i];
        assign s_axis_tlast[i]            = s_last[i];
        assign s_axis_tid[i*IW +: IW]     = s_id[i];
        assign s_axis_tuser[i*UW +: UW]   = s_user[i];
        assign m_axis_tready[i]           = m_ready[i];
        assign cfg_dest[i*SLW +: SLW]     = dest[i];
        assign s_ready[i]                 = s_axis_tready[i];
        assign m_valid[i]                 = m_axis_tvalid[i];
        assign m_last[i]                  = m_axis_tlast[i];
    end

    taxi_axis_frame_xbar #(
        .CNT(CNT), .DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .USER_W(UW), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tuser(m_axis_tuser),
        .cfg_dest(cfg_dest), .cfg_drop(cfg_drop), .stat_clr(stat_clr),
        .stat_tx_frames(stat_tx_frames), .stat_drop_frames(stat_drop_frames)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q [CNT][$];
    int    exp_tx [CNT];
    int    exp_drop [CNT];
    bit    rand_ready = 1'b0;
    beat_t mon_exp, mon_got;

    function automatic beat_t mk(input logic [DW-1:0] base, input int i, input int n,
                                 input logic [IW-1:0] id);
        beat_t b;
        b.data = DW'(int'(base) * (i + 1));
        b.keep = (i == n - 1) ? 2'b01 : 2'b11;
        b.last = (i == n - 1);
        b.id   = id;
        b.user = UW'(i & 1);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        for (int i = 0; i < CNT; i++) begin
            check($sformatf("%s tx%0d", tag, i), 32'(stat_tx_frames[i*SW +: SW]),
                  32'(exp_tx[i]));
            check($sformatf("%s drop%0d", tag, i), 32'(stat_drop_frames[i*SW +: SW]),
                  32'(exp_drop[i]));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < CNT; i++) begin
            exp_tx[i]   = 0;
            exp_drop[i] = 0;
        end
    endtask

    task automatic push_frame(input int o, input int n, input logic [DW-1:0] base,
                              input logic [IW-1:0] id);
        for (int i = 0; i < n; i++) exp_q[o].push_back(mk(base, i, n, id));
        if (exp_tx[o] != 15) exp_tx[o]++;
    endtask

    task automatic drive(input int p, input beat_t b);
        s_data[p] = b.data;
        s_keep[p] = b.keep;
        s_last[p] = b.last;
        s_id[p]   = b.id;
        s_user[p] = b.user;
        s_valid[p] = 1'b1;
    endtask

    // Drives one frame; cyc returns the number of cycles spent until the last handshake.
    task automatic send_frame(input int p, input int n, input logic [DW-1:0] base,
                              input logic [IW-1:0] id, output int cyc);
        bit to;
        cyc = 0;
        to  = 1'b0;
        for (int i = 0; i < n && !to; i++) begin
            drive(p, mk(base, i, n, id));
            forever begin
                @(negedge clk);
                cyc++;
                if (s_ready[p]) break;
                if (cyc > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL send timeout port %0d beat %0d", p, i);
                    to = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid[p] = 1'b0;
    endtask

    task automatic latency_check(input int p, input int o);
        @(negedge clk);
        check("lat c0 s_tready", 32'(s_ready[p]), 32'd0);
        check("lat c0 m_tvalid", 32'(m_valid[o]), 32'd0);
        @(negedge clk);
        check("lat c1 s_tready", 32'(s_ready[p]), 32'd1);
        check("lat c1 m_tvalid", 32'(m_valid[o]), 32'd0);
        @(negedge clk);
        check("lat c2 m_tvalid", 32'(m_valid[o]), 32'd1);
    endtask

    task automatic send_stream(input int p, input int nfr, input logic [DW-1:0] base,
                               input logic [IW-1:0] idb, input int len0, input int lstep);
        int c;
        for (int f = 0; f < nfr; f++) begin
            send_frame(p, len0 + f * lstep, base + DW'(f * 16), idb + IW'(f), c);
        end
    endtask

    task automatic push_stream(input int o, input int nfr, input logic [DW-1:0] base,
                               input logic [IW-1:0] idb, input int len0, input int lstep);
        for (int f = 0; f < nfr; f++) begin
            push_frame(o, len0 + f * lstep, base + DW'(f * 16), idb + IW'(f));
        end
    endtask

    task automatic gap_check(input int o, input int ngaps);
        int n;
        for (int g = 0; g < ngaps; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(m_valid[o] && m_last[o] && m_ready[o]) && n < 500);
            if (n >= 500) begin
                checks++;
                errors++;
                $display("FAIL gap wait timeout gap %0d", g);
                break;
            end
            @(negedge clk);
            check($sformatf("gap%0d idle", g), 32'(m_valid[o]), 32'd0);
            @(negedge clk);
            check($sformatf("gap%0d resume", g), 32'(m_valid[o]), 32'd1);
        end
    endtask

    task automatic wait_drain();
        int n;
        int tot;
        n = 0;
        do begin
            tick();
            n++;
            tot = 0;
            for (int i = 0; i < CNT; i++) tot += exp_q[i].size();
        end while (tot != 0 && n < 500);
        if (tot != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout actual_pending=%0d required=0", tot);
        end
        repeat (2) tick();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int o = 0; o < CNT; o++) begin
            if (!rst && m_valid[o] && m_ready[o]) begin
                mon_got = '{data: m_axis_tdata[o*DW +: DW], keep: m_axis_tkeep[o*KW +: KW],
                            last: m_axis_tlast[o], id: m_axis_tid[o*IW +: IW],
                            user: m_axis_tuser[o*UW +: UW]};
                checks++;
                if (exp_q[o].size() == 0) begin
                    errors++;
                    $display("FAIL out%0d unexpected beat actual=%h required=none", o, mon_got);
                end else begin
                    mon_exp = exp_q[o].pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL out%0d beat actual=%h required=%h", o, mon_got, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int o = 0; o < CNT; o++) begin
                m_ready[o] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin
        int c1;
        int c2;
        int ports [3];
        beat_t b;
        ports = '{0, 2, 3};
        for (int i = 0; i < CNT; i++) begin
            s_data[i] = '0; s_keep[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0;
            s_id[i] = '0; s_user[i] = '0; m_ready[i] = 1'b1; dest[i] = SLW'(i);
        end
        cfg_drop = '0;
        stat_clr = 1'b0;
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < CNT; i++) begin
            check($sformatf("reset m_tvalid%0d", i), 32'(m_valid[i]), 32'd0);
            check($sformatf("reset s_tready%0d", i), 32'(s_ready[i]), 32'd0);
        end
        check_counters("reset");
        rst = 1'b0;
        tick();

        // Loopback s0 -> m0 with latency
        dest[0] = 2'd0;
        dest[1] = 2'd1;
        push_frame(0, 3, 16'h0011, 8'd5);
        fork
            send_frame(0, 3, 16'h0011, 8'd5, c1);
            latency_check(0, 0);
        join
        wait_drain();
        check_counters("loopback");

        // Cross-connect under random backpressure
        dest[0] = 2'd1;
        dest[1] = 2'd0;
        push_stream(1, 3, 16'h1000, 8'h10, 2, 1);
        push_stream(0, 3, 16'h2000, 8'h20, 4, -1);
        rand_ready = 1'b1;
        fork
            send_stream(0, 3, 16'h1000, 8'h10, 2, 1);
            send_stream(1, 3, 16'h2000, 8'h20, 4, -1);
        join
        rand_ready = 1'b0;
        wait_drain();
        check_counters("cross");

        // Drop on s1, cfg_drop cleared mid-way through the second frame
        cfg_drop[1] = 1'b1;
        send_frame(1, 5, 16'h3000, 8'h31, c1);
        exp_drop[1]++;
        check("drop f1 cycles", 32'(c1), 32'd6);
        fork
            send_frame(1, 5, 16'h3100, 8'h32, c2);
            begin
                repeat (3) tick();
                cfg_drop[1] = 1'b0;
            end
        join
        exp_drop[1]++;
        check("drop f2 cycles", 32'(c2), 32'd6);
        push_frame(0, 2, 16'h3200, 8'h33);
        send_frame(1, 2, 16'h3200, 8'h33, c1);
        wait_drain();
        check_counters("drop");

        // Reset in beat 2 of a 4-beat frame s0 -> m0
        dest[0] = 2'd0;
        b = mk(16'h0300, 0, 4, 8'h34);
        exp_q[0].push_back(b);
        drive(0, b);
        tick();
        tick();
        drive(0, mk(16'h0300, 1, 4, 8'h34));
        tick();
        drive(0, mk(16'h0300, 2, 4, 8'h34));
        rst = 1'b1;
        #1;
        check("rst m_tvalid0", 32'(m_valid[0]), 32'd0);
        check("rst s_tready0", 32'(s_ready[0]), 32'd0);
        clear_model();
        check_counters("rst mid");
        s_valid[0] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        push_frame(0, 2, 16'h0350, 8'h35);
        fork
            send_frame(0, 2, 16'h0350, 8'h35, c1);
            latency_check(0, 0);
        join
        wait_drain();
        check_counters("post rst");

        // Contention: inputs 0, 2, 3 -> output 1, round-robin from port 0
        dest[0] = 2'd1;
        dest[2] = 2'd1;
        dest[3] = 2'd1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 3; k++) begin
                push_frame(1, 3, 16'h0400 + DW'(ports[k] * 256 + f * 16),
                           IW'(ports[k] * 16 + f));
            end
        end
        fork
            send_stream(0, 4, 16'h0400, 8'h00, 3, 0);
            send_stream(2, 4, 16'h0600, 8'h20, 3, 0);
            send_stream(3, 4, 16'h0700, 8'h30, 3, 0);
            gap_check(1, 11);
        join
        wait_drain();
        check_counters("contention");

        // Counter saturation, then clear coincident with a tlast
        dest[2] = 2'd2;
        for (int f = 0; f < 17; f++) begin
            push_frame(2, 1, 16'h0500 + DW'(f), 8'h50);
            send_frame(2, 1, 16'h0500 + DW'(f), 8'h50, c1);
        end
        wait_drain();
        check_counters("saturate");
        b = mk(16'h0555, 0, 1, 8'h55);
        exp_q[2].push_back(b);
        drive(2, b);
        tick();
        stat_clr = 1'b1;
        @(negedge clk);
        check("clr s_tready2", 32'(s_ready[2]), 32'd1);
        tick();
        stat_clr   = 1'b0;
        s_valid[2] = 1'b0;
        clear_model();
        exp_tx[2] = 1;
        check_counters("clr");
        wait_drain();

        c1 = 0;
        for (int i = 0; i < CNT; i++) c1 += exp_q[i].size();
        check("queues empty", 32'(c1), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
